// File: rtl/box_pkg.sv
// Shared types, screen constants and the next-position helper for the box motion path.
// Define BOX_MOTION_WRAP_EN to wrap at the screen edges instead of clamping.
package box_pkg;

   localparam int COORD_W      = 11;
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PENDING = 1'b1
   } state_t;

   // One axis: +step when only inc is set, -step when only dec is set, then clamp/wrap.
   function automatic logic [COORD_W-1:0] next_coord(
      input logic [COORD_W-1:0] pos,
      input logic               inc,
      input logic               dec,
      input logic [COORD_W-1:0] step,
      input logic [COORD_W-1:0] max_pos
   );
      logic signed [COORD_W:0] delta;
      logic signed [COORD_W:0] sum;
      delta = '0;
      if (inc && !dec)
         delta = $signed({1'b0, step});
      else if (dec && !inc)
         delta = -$signed({1'b0, step});
      sum = $signed({1'b0, pos}) + delta;
`ifdef BOX_MOTION_WRAP_EN
      if (sum[COORD_W])
         return max_pos;
      if (sum > $signed({1'b0, max_pos}))
         return '0;
`else
      if (sum[COORD_W])
         return '0;
      if (sum > $signed({1'b0, max_pos}))
         return max_pos;
`endif
      return sum[COORD_W-1:0];
   endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Button synchronizers and the move-tick prescaler feeding the box motion FSM.
module move_tick_gen #(
   parameter int TICK_DIV = 4_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   output logic [3:0] dir,
   output logic       tick
);

   localparam int CNT_W = $clog2(TICK_DIV);

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == CNT_W'(TICK_DIV - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= {right, left, down, up};
         r_sync2 <= r_sync1;
         r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign dir  = r_sync2;
   assign tick = w_last;

endmodule

// File: rtl/box_motion_ctrl.sv
// Paces box moves on the tick and commits them only on frame_start so a frame never tears.
// Edge behaviour (clamp vs wrap) is selected by BOX_MOTION_WRAP_EN in box_pkg.
module box_motion_ctrl
   import box_pkg::*;
#(
   parameter int TICK_DIV = 4_000_000,
   parameter int STEP     = 5,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int BOX_W    = 50,
   parameter int BOX_H    = 50,
   parameter int X_INIT   = 200,
   parameter int Y_INIT   = 100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               up,
   input  logic               down,
   input  logic               left,
   input  logic               right,
   input  logic               frame_start,
   output logic [COORD_W-1:0] box_x,
   output logic [COORD_W-1:0] box_y,
   output logic               pending,
   output logic               moved
);

   localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(H_ACTIVE - BOX_W);
   localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(V_ACTIVE - BOX_H);
   localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
   localparam logic [COORD_W-1:0] X_RST  = COORD_W'(X_INIT);
   localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(Y_INIT);

   logic [3:0]         w_dir;
   logic               w_tick;
   logic [COORD_W-1:0] w_nx;
   logic [COORD_W-1:0] w_ny;

   state_t             r_state;
   logic [COORD_W-1:0] r_box_x;
   logic [COORD_W-1:0] r_box_y;
   logic [COORD_W-1:0] r_nx;
   logic [COORD_W-1:0] r_ny;
   logic               r_pending;
   logic               r_moved;

   move_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .up   (up),
      .down (down),
      .left (left),
      .right(right),
      .dir  (w_dir),
      .tick (w_tick)
   );

   // dir = {right, left, down, up}
   assign w_nx = next_coord(r_box_x, w_dir[3], w_dir[2], STEP_C, X_MAX);
   assign w_ny = next_coord(r_box_y, w_dir[1], w_dir[0], STEP_C, Y_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_box_x   <= X_RST;
         r_box_y   <= Y_RST;
         r_nx      <= X_RST;
         r_ny      <= Y_RST;
         r_pending <= 1'b0;
         r_moved   <= 1'b0;
      end else begin
         r_moved <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_tick && (w_dir != 4'd0)) begin
                  r_nx      <= w_nx;
                  r_ny      <= w_ny;
                  r_pending <= 1'b1;
                  r_state   <= S_PENDING;
               end
            end
            // Ticks here are dropped; only the latched move is committed.
            S_PENDING: begin
               if (frame_start) begin
                  r_box_x   <= r_nx;
                  r_box_y   <= r_ny;
                  r_moved   <= 1'b1;
                  r_pending <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign box_x   = r_box_x;
   assign box_y   = r_box_y;
   assign pending = r_pending;
   assign moved   = r_moved;

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Directed bench for box_motion_ctrl with TICK_DIV=4, STEP=5; expected values are hand-derived.
module tb_box_motion_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
   logic        frame_start = 1'b0;
   logic [10:0] box_x, box_y;
   logic        pending, moved;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   box_motion_ctrl #(
      .TICK_DIV(4),
      .STEP    (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
      .frame_start(frame_start),
      .box_x      (box_x),
      .box_y      (box_y),
      .pending    (pending),
      .moved      (moved)
   );

   // d = {right, left, down, up}
   task automatic set_btn(input logic [3:0] d);
      {right, left, down, up} = d;
   endtask

   // Leaves the bench at the negedge where rst drops; the next posedge is tick-counter edge 1.
   task automatic apply_reset(input logic [3:0] d);
      @(negedge clk);
      rst = 1'b1;
      frame_start = 1'b0;
      set_btn(4'd0);
      repeat (2) @(negedge clk);
      set_btn(d);
      rst = 1'b0;
   endtask

   task automatic wait_pending(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pending) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_move(input logic [3:0] d, output bit ok);
      set_btn(d);
      wait_pending(ok);
      set_btn(4'd0);
   endtask

   // Returns at the negedge right after the committing posedge.
   task automatic commit();
      repeat (3) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset(4'd0);
      @(negedge clk);
      checks++; if (box_x !== 11'd200) begin errors++; $display("FAIL reset_box_x: got %0d expected 200", box_x); end
      checks++; if (box_y !== 11'd100) begin errors++; $display("FAIL reset_box_y: got %0d expected 100", box_y); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending); end
      checks++; if (moved !== 1'b0) begin errors++; $display("FAIL reset_moved: got %b expected 0", moved); end
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      checks++; if (moved !== 1'b0) begin errors++; $display("FAIL idle_frame_moved: got %b expected 0", moved); end
      checks++; if (box_x !== 11'd200) begin errors++; $display("FAIL idle_frame_box_x: got %0d expected 200", box_x); end
   endtask

   task automatic test_single_right();
      apply_reset(4'b1000);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++; if (pending !== 1'b0) begin errors++; $display("FAIL early_pending_c%0d: got %b expected 0", c, pending); end
      end
      @(negedge clk);
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL tick_pending: got %b expected 1", pending); end
      checks++; if (box_x !== 11'd200) begin errors++; $display("FAIL precommit_box_x: got %0d expected 200", box_x); end
      set_btn(4'd0);
      commit();
      checks++; if (box_x !== 11'd205) begin errors++; $display("FAIL right_box_x: got %0d expected 205", box_x); end
      checks++; if (box_y !== 11'd100) begin errors++; $display("FAIL right_box_y: got %0d expected 100", box_y); end
      checks++; if (moved !== 1'b1) begin errors++; $display("FAIL right_moved: got %b expected 1", moved); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL right_pending: got %b expected 0", pending); end
      @(negedge clk);
      checks++; if (moved !== 1'b0) begin errors++; $display("FAIL right_moved_pulse: got %b expected 0", moved); end
   endtask

   task automatic test_cancel_diagonal();
      bit ok;
      apply_reset(4'd0);
      do_move(4'b0111, ok);
      commit();
      checks++; if (!ok || box_x !== 11'd195) begin errors++; $display("FAIL cancel_box_x: got %0d expected 195 (ok=%b)", box_x, ok); end
      checks++; if (box_y !== 11'd100) begin errors++; $display("FAIL cancel_box_y: got %0d expected 100", box_y); end
      do_move(4'b1010, ok);
      commit();
      checks++; if (!ok || box_x !== 11'd200 || box_y !== 11'd105) begin errors++; $display("FAIL diag_rd: got %0d,%0d expected 200,105", box_x, box_y); end
      do_move(4'b0101, ok);
      commit();
      checks++; if (!ok || box_x !== 11'd195 || box_y !== 11'd100) begin errors++; $display("FAIL diag_lu: got %0d,%0d expected 195,100", box_x, box_y); end
   endtask

   task automatic test_edges();
      bit ok;
      int ex;
      apply_reset(4'd0);
      for (int i = 0; i < 78; i++) begin
         do_move(4'b1000, ok);
         commit();
         ex = 200 + 5 * (i + 1);
         checks++; if (!ok || box_x !== 11'(ex)) begin errors++; $display("FAIL walk_x_%0d: got %0d expected %0d", i, box_x, ex); end
      end
      do_move(4'b1000, ok);
      commit();
`ifdef BOX_MOTION_WRAP_EN
      ex = 0;
`else
      ex = 590;
`endif
      checks++; if (!ok || box_x !== 11'(ex)) begin errors++; $display("FAIL right_edge_x: got %0d expected %0d", box_x, ex); end
      checks++; if (moved !== 1'b1) begin errors++; $display("FAIL right_edge_moved: got %b expected 1", moved); end
      for (int i = 0; i < 20; i++) begin
         do_move(4'b0001, ok);
         commit();
         ex = 100 - 5 * (i + 1);
         checks++; if (!ok || box_y !== 11'(ex)) begin errors++; $display("FAIL walk_y_%0d: got %0d expected %0d", i, box_y, ex); end
      end
      do_move(4'b0001, ok);
      commit();
`ifdef BOX_MOTION_WRAP_EN
      ex = 430;
`else
      ex = 0;
`endif
      checks++; if (!ok || box_y !== 11'(ex)) begin errors++; $display("FAIL top_edge_y: got %0d expected %0d", box_y, ex); end
      checks++; if (moved !== 1'b1) begin errors++; $display("FAIL top_edge_moved: got %b expected 1", moved); end
   endtask

   task automatic test_no_accum();
      bit ok;
      apply_reset(4'd0);
      set_btn(4'b1000);
      wait_pending(ok);
      checks++; if (!ok) begin errors++; $display("FAIL hold_pending_timeout: got 0 expected 1"); end
      repeat (20) @(negedge clk);
      checks++; if (pending !== 1'b1 || box_x !== 11'd200 || moved !== 1'b0) begin errors++; $display("FAIL hold_state: got p=%b x=%0d m=%b expected p=1 x=200 m=0", pending, box_x, moved); end
      set_btn(4'd0);
      commit();
      checks++; if (box_x !== 11'd205 || moved !== 1'b1) begin errors++; $display("FAIL hold_commit: got x=%0d m=%b expected x=205 m=1", box_x, moved); end
      repeat (12) @(negedge clk);
      checks++; if (pending !== 1'b0 || box_x !== 11'd205) begin errors++; $display("FAIL hold_after: got p=%b x=%0d expected p=0 x=205", pending, box_x); end
   endtask

   task automatic test_reset_pending();
      bit ok;
      apply_reset(4'd0);
      do_move(4'b1000, ok);
      commit();
      do_move(4'b1010, ok);
      checks++; if (!ok || box_x !== 11'd205) begin errors++; $display("FAIL rp_setup: got x=%0d ok=%b expected x=205 ok=1", box_x, ok); end
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++; if (box_x !== 11'd200 || box_y !== 11'd100) begin errors++; $display("FAIL rp_box: got %0d,%0d expected 200,100", box_x, box_y); end
      checks++; if (pending !== 1'b0 || moved !== 1'b0) begin errors++; $display("FAIL rp_flags: got p=%b m=%b expected p=0 m=0", pending, moved); end
      @(negedge clk);
      rst = 1'b0;
      do_move(4'b1000, ok);
      commit();
      checks++; if (moved !== 1'b1) begin errors++; $display("FAIL rm_setup: got %b expected 1", moved); end
      #2 rst = 1'b1;
      #1;
      checks++; if (moved !== 1'b0 || box_x !== 11'd200) begin errors++; $display("FAIL rm_reset: got m=%b x=%0d expected m=0 x=200", moved, box_x); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_tick_frame_same();
      apply_reset(4'b1000);
      repeat (3) @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      set_btn(4'd0);
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL same_pending: got %b expected 1", pending); end
      checks++; if (box_x !== 11'd200 || moved !== 1'b0) begin errors++; $display("FAIL same_nocommit: got x=%0d m=%b expected x=200 m=0", box_x, moved); end
      @(negedge clk);
      checks++; if (box_x !== 11'd200 || moved !== 1'b0) begin errors++; $display("FAIL same_still: got x=%0d m=%b expected x=200 m=0", box_x, moved); end
      commit();
      checks++; if (box_x !== 11'd205 || moved !== 1'b1) begin errors++; $display("FAIL same_commit: got x=%0d m=%b expected x=205 m=1", box_x, moved); end
   endtask

   initial begin
      test_reset();
      test_single_right();
      test_cancel_diagonal();
      test_edges();
      test_no_accum();
      test_reset_pending();
      test_tick_frame_same();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
